dec_to_hex_encoder: RTL and testbench

Iterative decimal-to-binary encoder: converts an N-digit display-format decimal word (5-bit digit codes, MSD first, optional leading minus, decimal-point mask) into a 16-bit two's-complement value plus a decimal exponent. It sits on the TM1683 interface path opposite the hex-to-decimal display decoder. It turns front-panel numeric entry in display format back into parameter values for the synthesizer core. It processes one digit per clock with a shift-add ×10 accumulator and saturates to the 16-bit range.

---
 rtl/dec_to_hex_encoder.sv | 171 +++++++++++++++++
 tb/tb_dec_to_hex_encoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_to_hex_encoder.sv
// Display-format decimal word to signed 16-bit value plus decimal exponent.
// One digit field per clock, MSD first, with a saturating x10 accumulator.
module dec_to_hex_encoder #(
  parameter int N_DIGIT = 8
) (
  input  logic               mclk,
  input  logic               rst,
  input  logic               en,
  input  logic [39:0]        dec_in,
  input  logic [7:0]         point,
  output logic signed [15:0] hex_out,
  output logic signed [3:0]  exp,
  output logic               of,
  output logic               err,
  output logic               sync,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    SCAN = 3'b001,
    FIN  = 3'b111
  } state_t;

  localparam logic [2:0]  IDX_INIT = 3'(N_DIGIT - 1);
  localparam logic [7:0]  PT_VALID = 8'((16'd1 << N_DIGIT) - 16'd1);
  localparam logic [19:0] LIM_POS  = 20'd32767;
  localparam logic [19:0] LIM_NEG  = 20'd32768;
  localparam logic [4:0]  C_MINUS  = 5'h11;
  localparam logic [4:0]  C_BLANK  = 5'h1F;

  // Clamp to the magnitude limit of the current sign; MSB of result flags a clamp.
  function automatic logic [20:0] sat_acc(input logic [19:0] a, input logic neg);
    logic [19:0] lim;
    lim = neg ? LIM_NEG : LIM_POS;
    if (a > lim) return {1'b1, lim};
    return {1'b0, a};
  endfunction

  function automatic logic [19:0] mul10_add(input logic [19:0] a, input logic [3:0] d);
    return (a << 3) + (a << 1) + {16'd0, d};
  endfunction

  state_t      state_q, state_nxt;
  logic [39:0] dec_l;
  logic [7:0]  point_l;
  logic [4:0]  fld [8];
  logic [19:0] acc, acc_nxt;
  logic        sign, sign_nxt;
  logic        seen, seen_nxt;
  logic        of_acc, of_nxt;
  logic        err_acc, err_nxt;
  logic [2:0]  idx;
  logic [4:0]  code;
  logic [20:0] sat_res;

  logic               fin_err;
  logic [2:0]         pt_idx;
  logic signed [15:0] hex_fin;
  logic signed [3:0]  exp_fin;

  assign state = state_q;

  for (genvar g = 0; g < 8; g++) begin : g_fld
    assign fld[g] = dec_l[5*g +: 5];
  end

  always_ff @(posedge mclk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (en) state_nxt = SCAN;
      SCAN:    if (idx == 3'd0) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-field decode: digits accumulate, leading blanks/minus are framing only.
  always_comb begin
    code     = fld[idx];
    acc_nxt  = acc;
    sign_nxt = sign;
    seen_nxt = seen;
    of_nxt   = of_acc;
    err_nxt  = err_acc;
    sat_res  = sat_acc(mul10_add(acc, code[3:0]), sign);
    if (code <= 5'd9) begin
      acc_nxt  = sat_res[19:0];
      of_nxt   = of_acc | sat_res[20];
      seen_nxt = 1'b1;
    end else if (code == C_BLANK) begin
      if (seen) err_nxt = 1'b1;
    end else if (code == C_MINUS) begin
      if (seen || sign) err_nxt = 1'b1;
      else              sign_nxt = 1'b1;
    end else begin
      err_nxt = 1'b1;
    end
  end

  // Final result: framing checks that need the whole word happen here.
  always_comb begin
    pt_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (point_l[i]) pt_idx = 3'(i);
    end
    fin_err = err_acc | ~seen
            | (|(point_l & (point_l - 8'd1)))
            | (|(point_l & ~PT_VALID));
    exp_fin = 4'(4'd0 - {1'b0, pt_idx});
    hex_fin = sign ? 16'(16'd0 - acc[15:0]) : acc[15:0];
  end

  always_ff @(posedge mclk) begin
    if (en && state_q == IDLE) begin
      dec_l   <= dec_in;
      point_l <= point;
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      acc     <= '0;
      idx     <= IDX_INIT;
      sign    <= 1'b0;
      seen    <= 1'b0;
      of_acc  <= 1'b0;
      err_acc <= 1'b0;
      hex_out <= '0;
      exp     <= '0;
      of      <= 1'b0;
      err     <= 1'b0;
      sync    <= 1'b0;
    end else begin
      sync <= (state_q == FIN);
      case (state_q)
        IDLE: begin
          if (en) begin
            acc     <= '0;
            idx     <= IDX_INIT;
            sign    <= 1'b0;
            seen    <= 1'b0;
            of_acc  <= 1'b0;
            err_acc <= 1'b0;
          end
        end
        SCAN: begin
          acc     <= acc_nxt;
          sign    <= sign_nxt;
          seen    <= seen_nxt;
          of_acc  <= of_nxt;
          err_acc <= err_nxt;
          idx     <= idx - 3'd1;
        end
        FIN: begin
          err     <= fin_err;
          hex_out <= fin_err ? 16'sd0 : hex_fin;
          exp     <= fin_err ? 4'sd0  : exp_fin;
          of      <= fin_err ? 1'b0   : of_acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_to_hex_encoder.sv
// Directed-vector bench for dec_to_hex_encoder with hand-computed results.
module tb_dec_to_hex_encoder;

  logic               mclk = 1'b0;
  logic               rst;
  logic               en;
  logic [39:0]        dec_in;
  logic [7:0]         point;
  logic signed [15:0] hex_out;
  logic signed [3:0]  exp;
  logic               of, err, sync;
  logic [2:0]         state;

  int vec_cnt = 0;
  int miscmp  = 0;

  localparam logic [39:0] V_POS  = {5'h1F,5'h1F,5'h1F,5'h1F,5'h01,5'h02,5'h03,5'h04};
  localparam logic [39:0] V_NEG  = {5'h1F,5'h1F,5'h1F,5'h11,5'h00,5'h00,5'h04,5'h02};
  localparam logic [39:0] V_SATP = {5'h1F,5'h1F,5'h1F,5'h09,5'h09,5'h09,5'h09,5'h09};
  localparam logic [39:0] V_MIN  = {5'h1F,5'h1F,5'h11,5'h03,5'h02,5'h07,5'h06,5'h08};
  localparam logic [39:0] V_SATN = {5'h1F,5'h1F,5'h11,5'h04,5'h00,5'h00,5'h00,5'h00};

  dec_to_hex_encoder dut (
    .mclk   (mclk),
    .rst    (rst),
    .en     (en),
    .dec_in (dec_in),
    .point  (point),
    .hex_out(hex_out),
    .exp    (exp),
    .of     (of),
    .err    (err),
    .sync   (sync),
    .state  (state)
  );

  always #5 mclk = ~mclk;

  // Pulse en for one edge, scramble inputs afterwards, and wait (bounded) for sync.
  task automatic run_conv(input logic [39:0] d, input logic [7:0] p,
                          output int lat, output logic [2:0] st_fin);
    dec_in = d;
    point  = p;
    en     = 1'b1;
    @(posedge mclk); #1;
    en     = 1'b0;
    dec_in = 40'h0;
    point  = 8'hFF;
    lat    = 0;
    st_fin = 3'bxxx;
    for (int c = 1; c <= 20; c++) begin
      @(posedge mclk); #1;
      if (c == 8) st_fin = state;
      if (sync) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; dec_in = '0; point = '0;
    repeat (3) @(posedge mclk);
    #1;
    rst = 1'b0;
    vec_cnt++;
    if (state !== 3'b000) begin miscmp++; $display("FAIL reset_state got %b want 000", state); end
    vec_cnt++;
    if (hex_out !== 16'h0000 || exp !== 4'h0 || of !== 1'b0 || err !== 1'b0 || sync !== 1'b0) begin
      miscmp++;
      $display("FAIL reset_outputs got hex=%h exp=%h of=%b err=%b sync=%b want all zero",
               hex_out, exp, of, err, sync);
    end
  endtask

  task automatic test_positive;
    int lat; logic [2:0] st;
    run_conv(V_POS, 8'h00, lat, st);
    vec_cnt++;
    if (lat !== 9) begin miscmp++; $display("FAIL pos_latency got %0d want 9", lat); end
    vec_cnt++;
    if (st !== 3'b111) begin miscmp++; $display("FAIL pos_fin_state got %b want 111", st); end
    vec_cnt++;
    if (hex_out !== 16'h04D2 || exp !== 4'h0 || of !== 1'b0 || err !== 1'b0) begin
      miscmp++;
      $display("FAIL pos_value got hex=%h exp=%h of=%b err=%b want 04d2 0 0 0", hex_out, exp, of, err);
    end
    @(posedge mclk); #1;
    vec_cnt++;
    if (sync !== 1'b0 || state !== 3'b000) begin
      miscmp++; $display("FAIL pos_sync_width got sync=%b state=%b want 0 000", sync, state);
    end
    vec_cnt++;
    if (hex_out !== 16'h04D2) begin miscmp++; $display("FAIL pos_hold got %h want 04d2", hex_out); end
    run_conv(V_POS, 8'h80, lat, st);
    vec_cnt++;
    if (lat !== 9 || hex_out !== 16'h04D2 || exp !== 4'h9 || err !== 1'b0) begin
      miscmp++;
      $display("FAIL pos_point7 got lat=%0d hex=%h exp=%h err=%b want 9 04d2 9 0", lat, hex_out, exp, err);
    end
    @(posedge mclk); #1;
  endtask

  task automatic test_negative;
    int lat; logic [2:0] st;
    run_conv(V_NEG, 8'h02, lat, st);
    vec_cnt++;
    if (lat !== 9 || hex_out !== 16'hFFD6 || exp !== 4'hF || of !== 1'b0 || err !== 1'b0) begin
      miscmp++;
      $display("FAIL neg_value got lat=%0d hex=%h exp=%h of=%b err=%b want 9 ffd6 f 0 0",
               lat, hex_out, exp, of, err);
    end
    @(posedge mclk); #1;
    run_conv(V_MIN, 8'h00, lat, st);
    vec_cnt++;
    if (hex_out !== 16'h8000 || of !== 1'b0 || err !== 1'b0) begin
      miscmp++; $display("FAIL neg_boundary got hex=%h of=%b err=%b want 8000 0 0", hex_out, of, err);
    end
    @(posedge mclk); #1;
  endtask

  task automatic test_saturation;
    int lat; logic [2:0] st;
    run_conv(V_SATP, 8'h00, lat, st);
    vec_cnt++;
    if (hex_out !== 16'h7FFF || of !== 1'b1 || err !== 1'b0) begin
      miscmp++; $display("FAIL sat_pos got hex=%h of=%b err=%b want 7fff 1 0", hex_out, of, err);
    end
    @(posedge mclk); #1;
    run_conv(V_SATN, 8'h00, lat, st);
    vec_cnt++;
    if (hex_out !== 16'h8000 || of !== 1'b1 || err !== 1'b0) begin
      miscmp++; $display("FAIL sat_neg got hex=%h of=%b err=%b want 8000 1 0", hex_out, of, err);
    end
    @(posedge mclk); #1;
  endtask

  task automatic test_errors;
    logic [39:0] ev [9];
    logic [7:0]  ep [9];
    int lat; logic [2:0] st;
    ev[0] = {5'h1F,5'h1F,5'h1F,5'h1F,5'h01,5'h1F,5'h02,5'h03}; ep[0] = 8'h00;
    ev[1] = {8{5'h1F}};                                         ep[1] = 8'h00;
    ev[2] = {5'h1F,5'h1F,5'h1F,5'h1F,5'h1F,5'h01,5'h0A,5'h02}; ep[2] = 8'h00;
    ev[3] = V_POS;                                              ep[3] = 8'h05;
    ev[4] = {5'h1F,5'h1F,5'h1F,5'h1F,5'h1F,5'h1F,5'h1F,5'h11}; ep[4] = 8'h00;
    ev[5] = {5'h1F,5'h1F,5'h1F,5'h1F,5'h11,5'h11,5'h01,5'h02}; ep[5] = 8'h00;
    ev[6] = {5'h1F,5'h1F,5'h1F,5'h1F,5'h12,5'h01,5'h02,5'h03}; ep[6] = 8'h00;
    ev[7] = {5'h09,5'h09,5'h09,5'h09,5'h09,5'h09,5'h09,5'h1E}; ep[7] = 8'h00;
    ev[8] = {5'h1F,5'h1F,5'h1F,5'h1F,5'h01,5'h02,5'h11,5'h03}; ep[8] = 8'h00;
    for (int i = 0; i < 9; i++) begin
      run_conv(ev[i], ep[i], lat, st);
      vec_cnt++;
      if (lat !== 9 || err !== 1'b1 || hex_out !== 16'h0000 || exp !== 4'h0 || of !== 1'b0) begin
        miscmp++;
        $display("FAIL err_case%0d got lat=%0d err=%b hex=%h exp=%h of=%b want 9 1 0000 0 0",
                 i, lat, err, hex_out, exp, of);
      end
      @(posedge mclk); #1;
    end
    run_conv(V_POS, 8'h00, lat, st);
    vec_cnt++;
    if (err !== 1'b0 || hex_out !== 16'h04D2) begin
      miscmp++; $display("FAIL err_clears got err=%b hex=%h want 0 04d2", err, hex_out);
    end
    @(posedge mclk); #1;
  endtask

  task automatic test_reset_mid_scan;
    int lat; logic [2:0] st; int seen_sync;
    run_conv(V_SATP, 8'h01, lat, st);
    @(posedge mclk); #1;
    dec_in = V_POS; point = 8'h00; en = 1'b1;
    @(posedge mclk); #1;
    en = 1'b0;
    repeat (3) @(posedge mclk);
    #1;
    rst = 1'b1;
    @(posedge mclk); #1;
    rst = 1'b0;
    vec_cnt++;
    if (state !== 3'b000) begin miscmp++; $display("FAIL midrst_state got %b want 000", state); end
    vec_cnt++;
    if (hex_out !== 16'h0000 || exp !== 4'h0 || of !== 1'b0 || err !== 1'b0 || sync !== 1'b0) begin
      miscmp++;
      $display("FAIL midrst_outputs got hex=%h exp=%h of=%b err=%b sync=%b want all zero",
               hex_out, exp, of, err, sync);
    end
    seen_sync = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge mclk); #1;
      if (sync) seen_sync++;
    end
    vec_cnt++;
    if (seen_sync !== 0) begin miscmp++; $display("FAIL midrst_no_sync got %0d strobes want 0", seen_sync); end
    run_conv(V_POS, 8'h00, lat, st);
    vec_cnt++;
    if (lat !== 9 || hex_out !== 16'h04D2) begin
      miscmp++; $display("FAIL midrst_recover got lat=%0d hex=%h want 9 04d2", lat, hex_out);
    end
    @(posedge mclk); #1;
  endtask

  task automatic test_back_to_back;
    int t1, t2;
    t1 = 0; t2 = 0;
    dec_in = V_POS; point = 8'h00; en = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge mclk); #1;
      if (sync) begin
        if (t1 == 0) t1 = c;
        else begin
          t2 = c;
          en = 1'b0;
          break;
        end
      end
    end
    en = 1'b0;
    vec_cnt++;
    if (t1 !== 10) begin miscmp++; $display("FAIL b2b_first got %0d want 10", t1); end
    vec_cnt++;
    if (t2 - t1 !== 10) begin miscmp++; $display("FAIL b2b_gap got %0d want 10", t2 - t1); end
    vec_cnt++;
    if (hex_out !== 16'h04D2 || err !== 1'b0) begin
      miscmp++; $display("FAIL b2b_value got hex=%h err=%b want 04d2 0", hex_out, err);
    end
    repeat (3) @(posedge mclk);
    #1;
    vec_cnt++;
    if (state !== 3'b000) begin miscmp++; $display("FAIL b2b_idle got %b want 000", state); end
  endtask

  initial begin
    test_reset;
    test_positive;
    test_negative;
    test_saturation;
    test_errors;
    test_reset_mid_scan;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
